// File: rtl/debounce_multi.sv
// Multi-channel button/sensor debouncer: 2-FF synchroniser, stability window, press/release pulses.
// Optional hold auto-repeat is built when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi #(
    parameter int unsigned N_CH          = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          IDLE_LEVEL    = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_rep
);

    localparam int unsigned    CntW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [N_CH-1:0] IdleVec = {N_CH{IDLE_LEVEL}};

    if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("debounce_multi: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_CH-1:0] s1_q, s2_q;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [CntW-1:0] cnt_q [N_CH];
    logic [CntW-1:0] cnt_d [N_CH];

    // Any cycle where the synchronised input agrees with the level restarts the window.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = (s2_q[i] != IDLE_LEVEL);
                    release_d[i] = (s2_q[i] == IDLE_LEVEL);
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= IdleVec;
            s2_q      <= IdleVec;
            level_q   <= IdleVec;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned HoldMax =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned     HoldW      = $clog2(HoldMax + 1);
    localparam logic [HoldW-1:0] HoldLast   = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] HoldReload = HoldW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HoldW-1:0] hold_q [N_CH];
    logic [HoldW-1:0] hold_d [N_CH];
    logic [N_CH-1:0]  rep_q, rep_d;

    // Press/release edges clear the hold count; a repeat due on the release edge is dropped.
    always_comb begin
        rep_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            hold_d[i] = hold_q[i];
            if (press_d[i] || release_d[i]) begin
                hold_d[i] = '0;
            end else if (level_q[i] != IDLE_LEVEL) begin
                if (hold_q[i] == HoldLast) begin
                    rep_d[i]  = 1'b1;
                    hold_d[i] = HoldReload;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_rep = rep_q;
`else
    assign btn_rep = '0;
`endif

endmodule
